sram_fifo_controller: RTL and testbench
=======================================

SRAM_FIFO_CONTROLLER -- requirements
Module: sram_fifo_controller

Interface
REQ-001 SHALL have ports `Clk_In`, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port `Reset_In`, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have ports `Write_Data_In` (input, 16 bits, word to enqueue) and `Write_Valid_In` (input, 1 bit, enqueue request).
REQ-004 SHALL have port `Write_Ready_Out`, output, 1 bit: space available.
REQ-005 SHALL have ports `Read_Data_Out` (output, 16 bits, head word) and `Read_Valid_Out` (output, 1 bit, head word valid).
REQ-006 SHALL have port `Read_Ready_In`, input, 1 bit: consumer accepts head word.
REQ-007 SHALL have ports `Count_Out` (output, 9 bits, occupancy 0..256), `Full_Out` (output, 1 bit) and `Empty_Out` (output, 1 bit).
REQ-008 SHALL have SRAM port A outputs: `Port_A_Data_Out` (16 bits), `Port_A_Address_Out` (8 bits), `Port_A_Write_Enable_Out` (1 bit), `Port_A_Read_Enable_Out` (1 bit).
REQ-009 SHALL have SRAM port B outputs `Port_B_Address_Out` (8 bits), `Port_B_Read_Enable_Out` (1 bit), `Port_B_Write_Enable_Out` (1 bit), `Port_B_Data_Out` (16 bits), and input `Port_B_Data_In` (16 bits, SRAM port B read data).

Function
REQ-010 SHALL implement a 256-entry, 16-bit FIFO whose storage is the 256x16 dual-port SRAM: port A for writes only, port B for reads only.
REQ-011 SHALL tie `Port_A_Read_Enable_Out`, `Port_B_Write_Enable_Out` and `Port_B_Data_Out` to 0.
REQ-012 Push SHALL occur when `Write_Valid_In` && `Write_Ready_Out`.
REQ-013 `Write_Ready_Out` SHALL equal !`Full_Out`.
REQ-014 On a push, the block SHALL combinationally drive `Port_A_Write_Enable_Out`=1, `Port_A_Address_Out`=wr_ptr and `Port_A_Data_Out`=`Write_Data_In`, then increment wr_ptr (8 bits, wraps 255->0).
REQ-015 Pop SHALL occur when `Read_Valid_Out` && `Read_Ready_In`.
REQ-016 Occupancy counter (9 bits) SHALL be updated on each edge as follows:
- push only: +1
- pop only: -1
- push and pop: unchanged
REQ-017 `Count_Out` SHALL equal the occupancy counter.
REQ-018 `Full_Out` SHALL be asserted iff `Count_Out`==256; `Empty_Out` SHALL be asserted iff `Count_Out`==0.
REQ-019 An internal sram_count (9 bits) SHALL track words in SRAM not yet fetched:
- +1 per push
- -1 per fetch issue
- unchanged when both occur on the same edge
REQ-020 The SRAM read latency SHALL be exactly 1 cycle: `Port_B_Data_In` is valid in the cycle after `Port_B_Read_Enable_Out` is sampled high.
REQ-021 The read FSM SHALL have states EMPTY_S, FETCH_S and VALID_S, with reset state EMPTY_S.
REQ-022 In EMPTY_S, `Read_Valid_Out`=0; if sram_count>0, the FSM SHALL drive `Port_B_Read_Enable_Out`=1 and `Port_B_Address_Out`=rd_ptr, increment rd_ptr (wraps), and go to FETCH_S.
REQ-023 In FETCH_S, the FSM SHALL register `Port_B_Data_In` into `Read_Data_Out` at the edge and go to VALID_S.
REQ-024 In VALID_S, `Read_Valid_Out`=1 and `Read_Data_Out` SHALL be held stable until pop.
REQ-025 In VALID_S with a pop: if sram_count>0, the FSM SHALL issue a fetch (as REQ-022) and go to FETCH_S; otherwise it SHALL go to EMPTY_S.
REQ-026 `Port_B_Read_Enable_Out` SHALL be 0 in all cases not covered by REQ-022 and REQ-025.
REQ-027 Write-to-`Read_Valid_Out` latency SHALL be 2 cycles: for a push at edge E0 into an empty FIFO, `Read_Valid_Out` rises after edge E2.
REQ-028 Sustained read throughput SHALL be one word per 2 cycles.
REQ-029 A port A write and a port B read SHALL never target the same address in the same cycle; a fetch requires sram_count>0, which implies rd_ptr != wr_ptr unless full, and when full no push occurs.
REQ-030 When full, a push attempt SHALL be ignored: no SRAM write, no pointer or count change.
REQ-031 When empty, `Read_Ready_In` SHALL have no effect.
REQ-032 When `Count_Out`==256, a simultaneous push and pop SHALL NOT push (`Write_Ready_Out`=0), and the pop SHALL complete.

Reset
REQ-033 While `Reset_In`=1 at an edge, the block SHALL reset as follows:
- wr_ptr, rd_ptr, sram_count and occupancy to 0
- FSM to EMPTY_S
- `Read_Data_Out` to 16'h0000
- `Read_Valid_Out` to 0
REQ-034 After reset, `Count_Out`=0, `Empty_Out`=1, `Full_Out`=0 and `Write_Ready_Out`=1, and all SRAM enables SHALL be 0 on the cycle after reset.
REQ-035 Reset asserted mid-operation SHALL discard all queued and in-flight words; SRAM contents SHALL NOT be cleared by this block.
REQ-036 Reset SHALL take priority over a simultaneous push or pop.

Verification
REQ-037 Bench SHALL cover: reset, then push 16'hA5A5 with `Read_Ready_In`=0 -> SRAM write at address 0; `Read_Valid_Out`=1 with `Read_Data_Out`=16'hA5A5 two edges later; `Count_Out`=1.
REQ-038 Bench SHALL cover: push 256 words 16'h0000..16'h00FF with no pops -> `Full_Out`=1, `Write_Ready_Out`=0; a 257th push of 16'hFFFF is ignored; draining returns 0..255 in order, ending with `Empty_Out`=1.
REQ-039 Bench SHALL cover: push 300 words while popping continuously -> output order is preserved across the wr_ptr/rd_ptr wrap 255->0, and no `Port_A_Address_Out`==`Port_B_Address_Out` with both enables high in the same cycle.
REQ-040 Bench SHALL cover: at `Count_Out`==5 in VALID_S, push and pop on the same edge -> `Count_Out` stays 5 and the next head is the second-oldest word.
REQ-041 Bench SHALL cover: `Reset_In` pulse while `Count_Out`==10 in FETCH_S -> next cycle `Count_Out`=0, `Read_Valid_Out`=0; a new push of 16'h1234 writes SRAM address 0 and appears at `Read_Data_Out` two edges later.

Source files
------------

// File: rtl/sram_fifo_controller.sv
// 256-entry x 16-bit FIFO controller for an external dual-port SRAM.
// Port A only writes and port B only reads, with one cycle of read latency into a registered head word.
module sram_fifo_controller (
    input  logic        Clk_In,
    input  logic        Reset_In,
    input  logic [15:0] Write_Data_In,
    input  logic        Write_Valid_In,
    output logic        Write_Ready_Out,
    output logic [15:0] Read_Data_Out,
    output logic        Read_Valid_Out,
    input  logic        Read_Ready_In,
    output logic [8:0]  Count_Out,
    output logic        Full_Out,
    output logic        Empty_Out,
    output logic [15:0] Port_A_Data_Out,
    output logic [7:0]  Port_A_Address_Out,
    output logic        Port_A_Write_Enable_Out,
    output logic        Port_A_Read_Enable_Out,
    output logic [7:0]  Port_B_Address_Out,
    output logic        Port_B_Read_Enable_Out,
    output logic        Port_B_Write_Enable_Out,
    output logic [15:0] Port_B_Data_Out,
    input  logic [15:0] Port_B_Data_In
);

    typedef enum logic [1:0] {
        EMPTY_S,
        FETCH_S,
        VALID_S
    } rd_state_t;

    rd_state_t   state;
    rd_state_t   state_next;

    logic [7:0]  wr_ptr;
    logic [7:0]  rd_ptr;
    logic [8:0]  occupancy;
    logic [8:0]  sram_count;
    logic [15:0] read_data;

    logic        push;
    logic        pop;
    logic        fetch;
    logic        head_valid;
    logic        sram_has_data;

    // Handshake qualification; reset masks both sides so nothing moves on a reset edge.
    assign Full_Out        = (occupancy == 9'd256);
    assign Empty_Out       = (occupancy == 9'd0);
    assign Write_Ready_Out = !Full_Out;
    assign Count_Out       = occupancy;

    assign sram_has_data = (sram_count != 9'd0);
    assign push          = Write_Valid_In && Write_Ready_Out && !Reset_In;
    assign pop           = head_valid && Read_Ready_In && !Reset_In;

    // Port A: write-only
    assign Port_A_Write_Enable_Out = push;
    assign Port_A_Address_Out      = wr_ptr;
    assign Port_A_Data_Out         = Write_Data_In;
    assign Port_A_Read_Enable_Out  = 1'b0;

    // Port B: read-only
    assign Port_B_Read_Enable_Out  = fetch;
    assign Port_B_Address_Out      = rd_ptr;
    assign Port_B_Write_Enable_Out = 1'b0;
    assign Port_B_Data_Out         = '0;

    assign Read_Data_Out  = read_data;
    assign Read_Valid_Out = head_valid;

    // Read FSM: state register
    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            state <= EMPTY_S;
        end else begin
            state <= state_next;
        end
    end

    // Read FSM: next-state logic
    always_comb begin
        state_next = state;
        case (state)
            EMPTY_S: begin
                if (sram_has_data) begin
                    state_next = FETCH_S;
                end
            end
            FETCH_S: begin
                state_next = VALID_S;
            end
            VALID_S: begin
                if (pop) begin
                    state_next = sram_has_data ? FETCH_S : EMPTY_S;
                end
            end
            default: begin
                state_next = EMPTY_S;
            end
        endcase
    end

    // Read FSM: outputs
    always_comb begin
        head_valid = 1'b0;
        fetch      = 1'b0;
        case (state)
            EMPTY_S: begin
                fetch = sram_has_data && !Reset_In;
            end
            VALID_S: begin
                head_valid = 1'b1;
                fetch      = pop && sram_has_data;
            end
            default: begin
                head_valid = 1'b0;
                fetch      = 1'b0;
            end
        endcase
    end

    // Pointers, counters and the head-word register
    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occupancy  <= '0;
            sram_count <= '0;
            read_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 8'd1;
            end
            if (fetch) begin
                rd_ptr <= rd_ptr + 8'd1;
            end

            case ({push, pop})
                2'b10:   occupancy <= occupancy + 9'd1;
                2'b01:   occupancy <= occupancy - 9'd1;
                default: occupancy <= occupancy;
            endcase

            case ({push, fetch})
                2'b10:   sram_count <= sram_count + 9'd1;
                2'b01:   sram_count <= sram_count - 9'd1;
                default: sram_count <= sram_count;
            endcase

            // SRAM data is valid exactly one cycle after the fetch was issued
            if (state == FETCH_S) begin
                read_data <= Port_B_Data_In;
            end
        end
    end

    // A fetch needs unfetched data, so rd_ptr trails wr_ptr unless the FIFO is full (no push then).
    a_no_collision: assert property (@(posedge Clk_In) disable iff (Reset_In)
        !(Port_A_Write_Enable_Out && Port_B_Read_Enable_Out &&
          (Port_A_Address_Out == Port_B_Address_Out)));

    a_count_order: assert property (@(posedge Clk_In) disable iff (Reset_In)
        (sram_count <= occupancy) && (occupancy <= 9'd256));

endmodule

// File: tb/tb_sram_fifo_controller.sv
// Self-checking bench for sram_fifo_controller: queue-based behavioural model checked every cycle,
// plus directed scenarios with literal expectations, against a 256x16 one-cycle-latency SRAM model.
module tb_sram_fifo_controller;

    logic        clk;
    logic        reset;
    logic [15:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [8:0]  count;
    logic        full;
    logic        empty;
    logic [15:0] a_data;
    logic [7:0]  a_addr;
    logic        a_we;
    logic        a_re;
    logic [7:0]  b_addr;
    logic        b_re;
    logic        b_we;
    logic [15:0] b_wdata;
    logic [15:0] b_rdata;

    sram_fifo_controller dut (
        .Clk_In                  (clk),
        .Reset_In                (reset),
        .Write_Data_In           (wr_data),
        .Write_Valid_In          (wr_valid),
        .Write_Ready_Out         (wr_ready),
        .Read_Data_Out           (rd_data),
        .Read_Valid_Out          (rd_valid),
        .Read_Ready_In           (rd_ready),
        .Count_Out               (count),
        .Full_Out                (full),
        .Empty_Out               (empty),
        .Port_A_Data_Out         (a_data),
        .Port_A_Address_Out      (a_addr),
        .Port_A_Write_Enable_Out (a_we),
        .Port_A_Read_Enable_Out  (a_re),
        .Port_B_Address_Out      (b_addr),
        .Port_B_Read_Enable_Out  (b_re),
        .Port_B_Write_Enable_Out (b_we),
        .Port_B_Data_Out         (b_wdata),
        .Port_B_Data_In          (b_rdata)
    );

    // External SRAM: synchronous write on A, registered read on B
    logic [15:0] mem [256];
    initial b_rdata = '0;
    always @(posedge clk) begin
        if (a_we) mem[a_addr] <= a_data;
        if (b_re) b_rdata <= mem[b_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [15:0] q[$];
    logic [15:0] got[$];
    bit          model_on = 0;
    bit          in_flight;
    bit          shown;
    int          wr_cnt;
    int          rd_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare current outputs with the model, then advance the model across the coming edge.
    task automatic model_step();
        bit do_push;
        bit do_pop;
        bit do_fetch;
        int unfetched;
        if (reset) begin
            q.delete();
            in_flight = 0;
            shown     = 0;
            wr_cnt    = 0;
            rd_cnt    = 0;
            model_on  = 1;
            return;
        end
        if (!model_on) return;
        do_push   = wr_valid && (q.size() < 256);
        do_pop    = shown && rd_ready;
        unfetched = q.size() - int'(in_flight) - int'(shown);
        do_fetch  = (unfetched > 0) && ((!shown && !in_flight) || do_pop);

        check("m_count", 32'(count), 32'(q.size()));
        check("m_full", 32'(full), 32'(q.size() == 256));
        check("m_empty", 32'(empty), 32'(q.size() == 0));
        check("m_wr_ready", 32'(wr_ready), 32'(q.size() < 256));
        check("m_rd_valid", 32'(rd_valid), 32'(shown));
        if (shown) check("m_rd_data", 32'(rd_data), 32'(q[0]));
        check("m_a_we", 32'(a_we), 32'(do_push));
        if (do_push) begin
            check("m_a_addr", 32'(a_addr), 32'(wr_cnt % 256));
            check("m_a_data", 32'(a_data), 32'(wr_data));
        end
        check("m_b_re", 32'(b_re), 32'(do_fetch));
        if (do_fetch) check("m_b_addr", 32'(b_addr), 32'(rd_cnt % 256));
        check("m_collision", 32'(a_we && b_re && (a_addr == b_addr)), 32'd0);
        check("m_tieoffs", 32'({a_re, b_we, b_wdata}), 32'd0);

        if (rd_valid && rd_ready) got.push_back(rd_data);

        if (do_pop) begin
            void'(q.pop_front());
            shown = 0;
        end
        if (in_flight) begin
            shown     = 1;
            in_flight = 0;
        end
        if (do_fetch) begin
            in_flight = 1;
            rd_cnt++;
        end
        if (do_push) begin
            q.push_back(wr_data);
            wr_cnt++;
        end
    endtask

    // Advance one clock; inputs are changed only #1 after the rising edge.
    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (rd_valid) break;
            tick();
        end
        check("wait_valid", 32'(rd_valid), 32'd1);
    endtask

    task automatic drain(input int bound);
        rd_ready = 1'b1;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (empty) break;
        end
        rd_ready = 1'b0;
        check("drain_empty", 32'(empty), 32'd1);
    endtask

    task automatic check_got(input string name, input int n, input logic [15:0] base);
        int errs;
        logic [15:0] exp_w;
        errs = 0;
        check({name, "_size"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < got.size() && i < n; i++) begin
            exp_w = base + 16'(i);
            if (got[i] !== exp_w) errs++;
        end
        check({name, "_order"}, 32'(errs), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        wr_data  = '0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_enables", 32'({a_we, a_re, b_re, b_we}), 32'd0);

        // Single push with consumer stalled: two-edge latency to the head
        wr_data  = 16'hA5A5;
        wr_valid = 1'b1;
        #1;
        check("t1_a_we", 32'(a_we), 32'd1);
        check("t1_a_addr", 32'(a_addr), 32'd0);
        check("t1_a_data", 32'(a_data), 32'h0000A5A5);
        tick();
        wr_valid = 1'b0;
        #1;
        check("t1_fetch_issue", 32'(b_re), 32'd1);
        check("t1_e0_valid", 32'(rd_valid), 32'd0);
        tick();
        check("t1_e1_valid", 32'(rd_valid), 32'd0);
        tick();
        check("t1_e2_valid", 32'(rd_valid), 32'd1);
        check("t1_e2_data", 32'(rd_data), 32'h0000A5A5);
        check("t1_e2_count", 32'(count), 32'd1);
        drain(10);

        // Fill to 256, overflow attempt, full push+pop, then drain in order
        do_reset();
        for (int i = 0; i < 256; i++) begin
            wr_data  = 16'(i);
            wr_valid = 1'b1;
            tick();
        end
        wr_valid = 1'b0;
        #1;
        check("t2_full", 32'(full), 32'd1);
        check("t2_wr_ready", 32'(wr_ready), 32'd0);
        check("t2_count", 32'(count), 32'd256);
        got.delete();
        wr_data  = 16'hFFFF;
        wr_valid = 1'b1;
        #1;
        check("t2_ovf_no_write", 32'(a_we), 32'd0);
        tick();
        wr_valid = 1'b0;
        check("t2_ovf_count", 32'(count), 32'd256);
        wr_valid = 1'b1;
        rd_ready = 1'b1;
        #1;
        check("t2_full_pp_no_write", 32'(a_we), 32'd0);
        tick();
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        check("t2_full_pp_count", 32'(count), 32'd255);
        drain(1000);
        check_got("t2_drain", 256, 16'h0000);

        // 300 pushes with continuous popping; pointers wrap past 255
        got.delete();
        rd_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            wr_data  = 16'h1000 + 16'(i);
            wr_valid = 1'b1;
            tick();
        end
        wr_valid = 1'b0;
        drain(1000);
        check_got("t3_stream", 300, 16'h1000);

        // Simultaneous push and pop at count 5
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wr_data  = 16'h0050 + 16'(i);
            wr_valid = 1'b1;
            tick();
        end
        wr_valid = 1'b0;
        wait_valid(8);
        check("t4_count_before", 32'(count), 32'd5);
        check("t4_head_before", 32'(rd_data), 32'h00000050);
        wr_data  = 16'h0055;
        wr_valid = 1'b1;
        rd_ready = 1'b1;
        tick();
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        check("t4_count_after", 32'(count), 32'd5);
        check("t4_fetching", 32'(rd_valid), 32'd0);
        tick();
        check("t4_next_valid", 32'(rd_valid), 32'd1);
        check("t4_next_head", 32'(rd_data), 32'h00000051);

        // Reset in FETCH_S at count 10, with a push and pop requested on the reset edge
        do_reset();
        for (int i = 0; i < 10; i++) begin
            wr_data  = 16'h0060 + 16'(i);
            wr_valid = 1'b1;
            tick();
        end
        wr_valid = 1'b0;
        wait_valid(8);
        wr_data  = 16'h006A;
        wr_valid = 1'b1;
        rd_ready = 1'b1;
        tick();
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        check("t5_count10", 32'(count), 32'd10);
        check("t5_in_fetch", 32'(rd_valid), 32'd0);
        reset    = 1'b1;
        wr_data  = 16'hDEAD;
        wr_valid = 1'b1;
        rd_ready = 1'b1;
        #1;
        check("t5_rst_no_write", 32'(a_we), 32'd0);
        tick();
        reset    = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        #1;
        check("t5_rst_count", 32'(count), 32'd0);
        check("t5_rst_valid", 32'(rd_valid), 32'd0);
        check("t5_rst_b_re", 32'(b_re), 32'd0);
        wr_data  = 16'h1234;
        wr_valid = 1'b1;
        #1;
        check("t5_a_we", 32'(a_we), 32'd1);
        check("t5_a_addr", 32'(a_addr), 32'd0);
        tick();
        wr_valid = 1'b0;
        tick();
        check("t5_e1_valid", 32'(rd_valid), 32'd0);
        tick();
        check("t5_e2_valid", 32'(rd_valid), 32'd1);
        check("t5_e2_data", 32'(rd_data), 32'h00001234);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
